// File: rtl/receive_data.sv
// receive_data: 8-bit UART receiver with 16x oversampling, majority-vote bit sampling and a consumer handshake.
// Ports: clk (system clock), reset (async, active high), rxd (serial input, idles high),
//        rxdAck (clears rxdValid/rxdOverrun), rxdData (last good byte), rxdValid (unacknowledged byte present),
//        rxdBusy (frame in progress), rxdFrameErr (pulse on bad stop bit), rxdParityErr (pulse on parity mismatch),
//        rxdOverrun (sticky, a good byte overwrote an unacknowledged one).
// Build option: define RXD_PARITY_EN to receive one even-parity bit between the data and stop bits.
module receive_data #(
    parameter int ClkFrequency = 25000000,
    parameter int Baud = 9600,
    parameter int TickAccWidth = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rxdAck,
    output logic [7:0] rxdData,
    output logic       rxdValid,
    output logic       rxdBusy,
    output logic       rxdFrameErr,
    output logic       rxdParityErr,
    output logic       rxdOverrun
);
    // Rounded phase increment for a 16 x Baud tick; the accumulator MSB is the carry out.
    localparam logic [63:0] IncWide =
        ((64'(Baud) * 64'd16 << TickAccWidth) + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
    localparam logic [TickAccWidth:0] Inc = IncWide[TickAccWidth:0];

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RXD_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state;
    logic [TickAccWidth:0] acc;
    logic [1:0]            sync;
    logic [3:0]            cnt;
    logic [2:0]            bit_idx;
    logic [7:0]            shift;
    logic                  s7, s8;
    logic                  tick, rx, vote, stop_dec, par_err, good;

    assign tick     = acc[TickAccWidth];
    assign rx       = sync[1];
    assign vote     = (s7 & s8) | (s7 & rx) | (s8 & rx);
    assign stop_dec = tick & (state == STOP) & (cnt == 4'd9);
    assign good     = stop_dec & vote & ~par_err;
    assign rxdBusy  = state != IDLE;

`ifdef RXD_PARITY_EN
    logic par_bit;
    assign par_err = ^shift ^ par_bit;
    always_ff @(posedge clk or posedge reset)
        if (reset)
            par_bit <= 1'b0;
        else if (tick && state == PARITY && cnt == 4'd9)
            par_bit <= vote;
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            acc  <= '0;
            sync <= 2'b11;
        end else begin
            acc  <= {1'b0, acc[TickAccWidth-1:0]} + Inc;
            sync <= {sync[0], rxd};
        end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            s7           <= 1'b1;
            s8           <= 1'b1;
            rxdData      <= '0;
            rxdValid     <= 1'b0;
            rxdFrameErr  <= 1'b0;
            rxdParityErr <= 1'b0;
            rxdOverrun   <= 1'b0;
        end else begin
            // A bad stop bit outranks a parity mismatch, so the two never pulse together.
            rxdFrameErr  <= stop_dec & ~vote;
            rxdParityErr <= stop_dec & vote & par_err;
            if (good) begin
                rxdData    <= shift;
                rxdValid   <= 1'b1;
                rxdOverrun <= ~rxdAck & (rxdValid | rxdOverrun);
            end else if (rxdAck) begin
                rxdValid   <= 1'b0;
                rxdOverrun <= 1'b0;
            end
            if (tick) begin
                cnt <= cnt + 4'd1;
                if (cnt == 4'd7) s7 <= rx;
                if (cnt == 4'd8) s8 <= rx;
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (!rx) state <= START;
                    end
                    START:
                        if (cnt == 4'd9 && vote) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == 4'd15) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    DATA: begin
                        if (cnt == 4'd9) shift <= {vote, shift[7:1]};
                        if (cnt == 4'd15) begin
                            bit_idx <= bit_idx + 3'd1;
`ifdef RXD_PARITY_EN
                            if (bit_idx == 3'd7) state <= PARITY;
`else
                            if (bit_idx == 3'd7) state <= STOP;
`endif
                        end
                    end
`ifdef RXD_PARITY_EN
                    PARITY:
                        if (cnt == 4'd15) state <= STOP;
`endif
                    STOP:
                        // Leave mid stop bit so an immediately following start edge is seen.
                        if (cnt == 4'd9) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
